// File: rtl/i2s_adc_receiver.sv
// rtl/i2s_adc_receiver.sv - I2S ADC single-slot receiver feeding signed samples to the FIR
module i2s_adc_receiver #(
  parameter int DataWidth  = 12,
  parameter int SlotWidth  = 32,
  parameter bit ChannelSel = 1'b0
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        sclk,
  input  logic                        lrck,
  input  logic                        adc,
  output logic signed [DataWidth-1:0] adcData,
  output logic                        adcDataValid,
  output logic                        shortSlot
);

  localparam int IdxW = $clog2(SlotWidth + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SKIP  = 3'd1,
    SHIFT = 3'd2,
    LOAD  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t               state;
  logic                 sclk_q;
  logic                 sclk_qq;
  logic                 lrck_q;
  logic                 adc_q;
  logic                 lrck_prev;
  logic                 primed;
  logic [IdxW-1:0]      idx;
  logic [IdxW-1:0]      idx_next;
  logic [DataWidth-1:0] shreg;
  logic                 rise;
  logic                 transition;

  // A rise event is the single clk where the registered sclk has just gone high.
  assign rise = sclk_q & ~sclk_qq;

  // The very first rise after reset has no previous lrck to compare against, so it
  // only primes the tracker; a slot in progress at reset release never counts as a
  // transition and the first partial frame is dropped.
  assign transition = rise & primed & (lrck_q != lrck_prev);

  // Bit index of the current rise within the slot, saturating at the slot length.
  assign idx_next = (idx == IdxW'(SlotWidth)) ? idx : idx + IdxW'(1);

  // Register the raw I2S pins once, plus a second sclk stage for edge detection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sclk_q  <= 1'b0;
      sclk_qq <= 1'b0;
      lrck_q  <= 1'b0;
      adc_q   <= 1'b0;
    end else begin
      sclk_q  <= sclk;
      sclk_qq <= sclk_q;
      lrck_q  <= lrck;
      adc_q   <= adc;
    end
  end

  // Track lrck across rise events and keep the in-slot bit index.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      primed    <= 1'b0;
      lrck_prev <= 1'b0;
      idx       <= '0;
    end else if (rise) begin
      primed    <= 1'b1;
      lrck_prev <= lrck_q;
      idx       <= transition ? '0 : idx_next;
    end
  end

  // Capture FSM: skip the delay bit, shift DataWidth bits of the selected slot, then publish.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      shreg        <= '0;
      adcData      <= '0;
      adcDataValid <= 1'b0;
      shortSlot    <= 1'b0;
    end else begin
      adcDataValid <= 1'b0;
      case (state)
        IDLE: begin
          if (transition) state <= SKIP;
        end
        SKIP: begin
          if (transition) begin
            state <= SKIP;
          end else if (rise) begin
            if (lrck_q == ChannelSel) begin
              shreg <= DataWidth'(adc_q);
              state <= (DataWidth == 1) ? LOAD : SHIFT;
            end else begin
              state <= WAIT;
            end
          end
        end
        SHIFT: begin
          if (transition) begin
            // Slot ended early: drop the partial word and treat this rise as index 0.
            shortSlot <= 1'b1;
            state     <= SKIP;
          end else if (rise) begin
            shreg <= (shreg << 1) | DataWidth'(adc_q);
            if (idx_next == IdxW'(DataWidth)) state <= LOAD;
          end
        end
        LOAD: begin
          adcData      <= $signed(shreg);
          adcDataValid <= 1'b1;
          state        <= transition ? SKIP : WAIT;
        end
        WAIT: begin
          if (transition) state <= SKIP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// tb/tb_i2s_adc_receiver.sv - directed bench for i2s_adc_receiver, left and right slot instances
module tb_i2s_adc_receiver;

  localparam int DW = 12;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          sclk = 1'b0;
  logic          lrck = 1'b0;
  logic          adc = 1'b0;
  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic          v0;
  logic          v1;
  logic          s0;
  logic          s1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_e0 = 0;
  int n0 = 0;
  int n1 = 0;
  int cyc0 = 0;
  int cyc1 = 0;
  int wide0 = 0;
  int wide1 = 0;
  logic v0_d = 1'b0;
  logic v1_d = 1'b0;

  always #5 clk = ~clk;

  i2s_adc_receiver #(.DataWidth(DW), .SlotWidth(SW), .ChannelSel(1'b0)) u_left (
    .clk          (clk),
    .resetN       (resetN),
    .sclk         (sclk),
    .lrck         (lrck),
    .adc          (adc),
    .adcData      (d0),
    .adcDataValid (v0),
    .shortSlot    (s0)
  );

  i2s_adc_receiver #(.DataWidth(DW), .SlotWidth(SW), .ChannelSel(1'b1)) u_right (
    .clk          (clk),
    .resetN       (resetN),
    .sclk         (sclk),
    .lrck         (lrck),
    .adc          (adc),
    .adcData      (d1),
    .adcDataValid (v1),
    .shortSlot    (s1)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (v0) begin
      if (v0_d) wide0++;
      else begin
        n0++;
        cyc0 = cyc;
      end
    end
    if (v1) begin
      if (v1_d) wide1++;
      else begin
        n1++;
        cyc1 = cyc;
      end
    end
    v0_d = v0;
    v1_d = v1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Bit periods first..last of one slot; index 0 is the delay bit, 1..24 carry w MSB-first.
  task automatic send_bits(input logic l, input logic [23:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      sclk = 1'b0;
      lrck = l;
      adc  = (i >= 1 && i <= 24) ? w[24-i] : 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      if (i == DW) last_e0 = cyc + 1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_slot(input logic l, input logic [23:0] w);
    send_bits(l, w, 0, SW - 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int snap0;
    int snap1;

    // Reset held with sclk toggling
    @(negedge clk);
    send_bits(1'b0, 24'hFFFFFF, 0, 9);
    check("rst_data0", int'(d0), 0);
    check("rst_valid0", int'(v0), 0);
    check("rst_short0", int'(s0), 0);
    check("rst_data1", int'(d1), 0);
    check("rst_valid1", int'(v1), 0);
    check("rst_short1", int'(s1), 0);

    // Release mid left slot: partial frame gives nothing
    resetN = 1'b1;
    send_bits(1'b0, 24'hFFFFFF, 10, SW - 1);
    check("partial_n0", n0, 0);
    check("partial_n1", n1, 0);
    send_slot(1'b1, 24'h000000);
    check("first_right_n1", n1, 1);
    check("first_right_n0", n0, 0);

    // Left capture 0x7FF
    send_slot(1'b0, 24'h7FF000);
    check("left7ff_n0", n0, 1);
    check("left7ff_data", int'(d0), 12'h7FF);
    check("left7ff_signed", int'($signed(d0)), 2047);
    check("left7ff_latency", cyc0 - last_e0, 2);
    send_slot(1'b1, 24'h000000);
    check("right_slot_no_strobe0", n0, 1);
    check("right_zero_n1", n1, 2);

    // Negative value, MSB alignment
    send_slot(1'b0, 24'hABCDEF);
    check("abc_n0", n0, 2);
    check("abc_data", int'(d0), 12'hABC);
    check("abc_signed", int'($signed(d0)), -1348);
    send_slot(1'b1, 24'h123456);
    check("abc_hold_n0", n0, 2);
    check("abc_hold_data", int'(d0), 12'hABC);
    check("right123_data1", int'(d1), 12'h123);
    check("right123_n1", n1, 3);

    // Four frames, right channel select
    snap0 = n0;
    snap1 = n1;
    for (int f = 0; f < 4; f++) begin
      send_slot(1'b0, 24'h111111);
      send_slot(1'b1, 24'h800000);
    end
    check("four_frames_n1", n1 - snap1, 4);
    check("four_frames_n0", n0 - snap0, 4);
    check("right800_data1", int'(d1), 12'h800);
    check("right800_signed1", int'($signed(d1)), -2048);
    check("left111_data0", int'(d0), 12'h111);

    // Short left slot: delay bit plus 5 data bits
    snap0 = n0;
    send_bits(1'b0, 24'hFFFFFF, 0, 5);
    send_slot(1'b1, 24'h5A5000);
    check("short_flag0", int'(s0), 1);
    check("short_no_strobe0", n0 - snap0, 0);
    check("short_hold_data0", int'(d0), 12'h111);
    check("short_flag1", int'(s1), 0);
    check("short_right_data1", int'(d1), 12'h5A5);
    send_slot(1'b0, 24'h321000);
    check("after_short_n0", n0 - snap0, 1);
    check("after_short_data0", int'(d0), 12'h321);
    check("short_sticky0", int'(s0), 1);
    send_slot(1'b1, 24'h000000);

    // Reset mid-SHIFT after 6 data bits
    send_bits(1'b0, 24'hFFF000, 0, 6);
    snap0 = n0;
    resetN = 1'b0;
    #1;
    check("midrst_data0", int'(d0), 0);
    check("midrst_valid0", int'(v0), 0);
    check("midrst_short0", int'(s0), 0);
    check("midrst_data1", int'(d1), 0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    send_bits(1'b0, 24'hFFF000, 7, SW - 1);
    check("midrst_rest_n0", n0 - snap0, 0);
    send_slot(1'b1, 24'h000000);
    check("midrst_right_n0", n0 - snap0, 0);
    send_slot(1'b0, 24'h456000);
    check("midrst_recover_n0", n0 - snap0, 1);
    check("midrst_recover_data0", int'(d0), 12'h456);

    check("strobe_width0", wide0, 0);
    check("strobe_width1", wide1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_adc_receiver.md
# i2s_adc_receiver

Receives one channel of the I2S ADC stream on the I2S2 Pmod and delivers signed samples to the FIR input. It sits directly upstream of the FIR: `adcData`/`adcDataValid` connect to the FIR `x`/`start`. The I2S controller generates `sclk` and `lrck` from `clk`, so this block oversamples them in the `clk` domain, captures the top `DataWidth` bits of the selected slot MSB-first, and pulses a valid strobe once per frame.

## Interface
- `DataWidth`, 12: output sample width in bits. Must satisfy 1 ≤ DataWidth ≤ SlotWidth−1.
- `SlotWidth`, 32: sclk periods per lrck half-frame. Used only for counter sizing; the counter saturates at SlotWidth.
- `ChannelSel`, 0: slot to capture. 0 = left (lrck low), 1 = right (lrck high).
- `clk` input 1: system clock. Single clock domain for the whole block.
- `resetN` input 1: reset, asynchronous and active-low.
- `sclk` input 1: I2S bit clock, synchronous to `clk`. High and low phases are each ≥2 clk cycles.
- `lrck` input 1: I2S word select. Changes on sclk falling edges.
- `adc` input 1: serial ADC data. Changes on sclk falling edges.
- `adcData` output DataWidth: signed two's-complement sample, MSB-first capture. Holds its value between strobes.
- `adcDataValid` output 1: one-clk pulse when `adcData` is updated.
- `shortSlot` output 1: sticky error flag, cleared only by reset.

## Operation
- Input stage: `sclk`, `lrck` and `adc` are each registered once (`*_q`). A second register on sclk (`sclk_qq`) is used for edge detection.
- sclk rise event: `sclk_q`=1 and `sclk_qq`=0. All sampling happens only on rise events, using `lrck_q` and `adc_q`.
- lrck transition: on a rise event where `lrck_q` differs from the lrck value held from the previous rise event.
- Bit index: a transition rise is index 0, the I2S delay bit, which is ignored. Indices 1..DataWidth are captured MSB-first into the shift register. Later indices are ignored. The index counter saturates at SlotWidth.
- FSM states:
  - IDLE: entered on reset. Waits for the first lrck transition, so the first partial frame is always discarded. On a transition, goes to SKIP.
  - SKIP: index 0 has been consumed. On the next rise event, if the new slot's lrck equals ChannelSel, capture bit 1 and go to SHIFT. Otherwise go to WAIT.
  - SHIFT: shift `adc_q` in on each rise event. When bit DataWidth is shifted in, go to LOAD.
  - LOAD: lasts one clk. Copy the shift register to `adcData`, assert `adcDataValid`, go to WAIT.
  - WAIT: ignore data. On an lrck transition, go to SKIP.
- lrck transition while in SHIFT (fewer than DataWidth bits captured):
  - set `shortSlot`;
  - discard the partial word, with no strobe and `adcData` unchanged;
  - treat the rise as index 0 of the new slot and go to SKIP.
- Samples are forwarded exactly as received. There is no scaling, rounding or saturation.
- The non-selected slot never produces a strobe.

## Timing
- Reset values: `adcData`=0, `adcDataValid`=0, `shortSlot`=0, FSM=IDLE, all internal registers 0.
- Reset asserted mid-word: outputs clear immediately (asynchronous). After release, the block waits in IDLE for a full lrck transition before any capture.
- Latency, with clk edge E0 being the edge where `sclk_q` first samples 1 for bit DataWidth:
  - E1: rise event; bit DataWidth is shifted in.
  - E2: `adcData` updates and `adcDataValid`=1.
  - E3: `adcDataValid`=0.
- `adcDataValid` is exactly one clk wide and occurs at most once per lrck frame.
- Throughput: one sample per lrck period.
- The FIR consumes the strobe without backpressure. No handshake is returned.
- `shortSlot` rises on the clk edge that processes the offending transition rise event.

## Test plan
- Reset then idle: hold `resetN`=0 with sclk toggling. Required: `adcData`=0, `adcDataValid`=0, `shortSlot`=0. After release, the first partial frame gives no strobe.
- Left capture: DataWidth=12, ChannelSel=0, sclk=clk/8, left word 0x7FF followed by zeros. Required: `adcData`=0x7FF (+2047) and a one-cycle strobe 2 clk edges after bit 12 is sampled. No strobe during the right slot.
- Negative value and MSB alignment: 24-bit left word 0xABCDEF. Required: `adcData`=0xABC, which reads as −1348 signed. The right slot carries 0x123456 and is ignored.
- Right channel select: ChannelSel=1, left=0x111111, right=0x800000. Required: `adcData`=0x800 (−2048), strobe only after the right slot. Across 4 frames there are exactly 4 strobes.
- Short slot: toggle lrck after only 5 left-slot bits. Required: `shortSlot`=1 and sticky, no strobe, `adcData` unchanged. The next full frame captures correctly.
- Reset mid-SHIFT: assert `resetN`=0 after 6 bits. Required: outputs clear immediately. After release, no strobe until one full transition followed by DataWidth bits.
